reg_file_wb: RTL and testbench

Architectural register file and write-back scoreboard for the 5-stage pipeline CPU. It is the receiving end of the WB stage: it consumes the write register, write data and RegWrite signals, and commits them on the clock edge. It also serves the two ID-stage read ports with same-cycle write-through bypass. A per-register pending-write counter tells decode which source operands still have an in-flight producer.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 79 +++++++
 rtl/reg_file_wb.sv | 65 ++++++
 tb/tb_reg_file_wb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file and its scoreboard.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  // Hard-wired zero register index
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Per-register count of issued-but-not-retired writers
  typedef logic [CNT_W-1:0] pend_cnt_t;

  localparam pend_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register tracking
// in-flight producers, plus decode busy flags, issue stall and a sticky
// underflow error.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_reg1,
  input  logic [ADDR_W-1:0] i_rd_reg2,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic              i_retire_en,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_reg,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_issue_full,
  output logic              o_err
);

  pend_cnt_t cnt_q [NUM_REGS];
  pend_cnt_t cnt_d [NUM_REGS];
  logic      err_q, err_d;
  logic      issue, retire;

  // Issue/retire qualification and the decode stall
  always_comb begin
    o_issue_full = (i_issue_reg != REG_ZERO) && (cnt_q[i_issue_reg] == CNT_MAX);
    retire       = i_retire_en && (i_write_reg != REG_ZERO);
    issue        = i_issue_valid && (i_issue_reg != REG_ZERO) && !o_issue_full;
  end

  // Busy flags; a last producer retiring this cycle is covered by bypass
  always_comb begin
    o_busy1 = (i_rd_reg1 != REG_ZERO) && (cnt_q[i_rd_reg1] != '0) &&
              !(retire && (i_write_reg == i_rd_reg1) && (cnt_q[i_rd_reg1] == pend_cnt_t'(1)));
    o_busy2 = (i_rd_reg2 != REG_ZERO) && (cnt_q[i_rd_reg2] != '0) &&
              !(retire && (i_write_reg == i_rd_reg2) && (cnt_q[i_rd_reg2] == pend_cnt_t'(1)));
  end

  // Counter next state; simultaneous issue and retire on one register cancel
  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (issue && (i_issue_reg == ADDR_W'(r)) &&
          !(retire && (i_write_reg == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (retire && (i_write_reg == ADDR_W'(r)) &&
                   !(issue && (i_issue_reg == ADDR_W'(r))) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    cnt_d[0] = '0;
    if (retire && (cnt_q[i_write_reg] == '0)) begin
      err_d = 1'b1;
    end
  end

  // Counter and error state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign o_err = err_q;

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file at the WB stage: commit storage, two read
// ports with same-cycle write-through bypass, and the pending-write scoreboard.
module reg_file_wb
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_reg1,
  input  logic [ADDR_W-1:0] i_rd_reg2,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_busy1,
  output logic              o_busy2,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_RegWrite,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_reg,
  output logic              o_issue_full,
  output logic              o_err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  // Reset masks the commit strobe so reset forces all read outputs to zero
  assign wr_en = i_RegWrite && !i_rst && (i_write_reg != REG_ZERO);

  // Register storage; r0 is never written
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_write_reg] <= i_write_data;
    end
  end

  // Read ports with write-through bypass
  always_comb begin
    o_rd_data1 = regs_q[i_rd_reg1];
    o_rd_data2 = regs_q[i_rd_reg2];
    if (wr_en && (i_write_reg == i_rd_reg1)) o_rd_data1 = i_write_data;
    if (wr_en && (i_write_reg == i_rd_reg2)) o_rd_data2 = i_write_data;
    if (i_rd_reg1 == REG_ZERO) o_rd_data1 = '0;
    if (i_rd_reg2 == REG_ZERO) o_rd_data2 = '0;
  end

  reg_scoreboard u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rd_reg1     (i_rd_reg1),
    .i_rd_reg2     (i_rd_reg2),
    .i_write_reg   (i_write_reg),
    .i_retire_en   (wr_en),
    .i_issue_valid (i_issue_valid),
    .i_issue_reg   (i_issue_reg),
    .o_busy1       (o_busy1),
    .o_busy2       (o_busy2),
    .o_issue_full  (o_issue_full),
    .o_err         (o_err)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and randomized checks of reg_file_wb against an array-based model.
module tb_reg_file_wb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_rd_reg1, i_rd_reg2, i_write_reg, i_issue_reg;
  logic [31:0] i_write_data;
  logic        i_RegWrite, i_issue_valid;
  logic [31:0] o_rd_data1, o_rd_data2;
  logic        o_busy1, o_busy2, o_issue_full, o_err;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values, pending counts, sticky error
  logic [31:0] regs_m [32];
  int          cnt_m  [32];
  bit          err_m;

  always #5 i_clk = ~i_clk;

  reg_file_wb dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rd_reg1     (i_rd_reg1),
    .i_rd_reg2     (i_rd_reg2),
    .o_rd_data1    (o_rd_data1),
    .o_rd_data2    (o_rd_data2),
    .o_busy1       (o_busy1),
    .o_busy2       (o_busy2),
    .i_write_reg   (i_write_reg),
    .i_write_data  (i_write_data),
    .i_RegWrite    (i_RegWrite),
    .i_issue_valid (i_issue_valid),
    .i_issue_reg   (i_issue_reg),
    .o_issue_full  (o_issue_full),
    .o_err         (o_err)
  );

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      regs_m[r] = '0;
      cnt_m[r]  = 0;
    end
    err_m = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return '0;
    if (i_RegWrite && !i_rst && i_write_reg == idx) return i_write_data;
    return regs_m[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (i_RegWrite && !i_rst && i_write_reg == idx && cnt_m[idx] == 1) return 1'b0;
    return cnt_m[idx] != 0;
  endfunction

  task automatic drive(input logic [4:0] rd1, input logic [4:0] rd2, input logic we,
                       input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic iv, input logic [4:0] ireg);
    i_rd_reg1 = rd1; i_rd_reg2 = rd2; i_RegWrite = we; i_write_reg = wreg;
    i_write_data = wdata; i_issue_valid = iv; i_issue_reg = ireg;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_d1, e_d2;
    logic        e_b1, e_b2, e_full;
    #1;
    e_d1   = exp_rd(i_rd_reg1);
    e_d2   = exp_rd(i_rd_reg2);
    e_b1   = exp_busy(i_rd_reg1);
    e_b2   = exp_busy(i_rd_reg2);
    e_full = (i_issue_reg != 0) && (cnt_m[i_issue_reg] == 3);
    checks += 6;
    assert (o_rd_data1 === e_d1) else begin
      errors++; $error("FAIL %s rd_data1 got %h exp %h", tag, o_rd_data1, e_d1);
    end
    assert (o_rd_data2 === e_d2) else begin
      errors++; $error("FAIL %s rd_data2 got %h exp %h", tag, o_rd_data2, e_d2);
    end
    assert (o_busy1 === e_b1) else begin
      errors++; $error("FAIL %s busy1 got %b exp %b", tag, o_busy1, e_b1);
    end
    assert (o_busy2 === e_b2) else begin
      errors++; $error("FAIL %s busy2 got %b exp %b", tag, o_busy2, e_b2);
    end
    assert (o_issue_full === e_full) else begin
      errors++; $error("FAIL %s issue_full got %b exp %b", tag, o_issue_full, e_full);
    end
    assert (o_err === err_m) else begin
      errors++; $error("FAIL %s err got %b exp %b", tag, o_err, err_m);
    end
  endtask

  // Advance one clock and apply the architectural effect of that edge
  task automatic tick();
    bit retire, issue;
    @(posedge i_clk);
    if (i_rst) begin
      model_clear();
    end else begin
      retire = i_RegWrite && i_write_reg != 0;
      issue  = i_issue_valid && i_issue_reg != 0 && cnt_m[i_issue_reg] != 3;
      if (retire) regs_m[i_write_reg] = i_write_data;
      if (retire && cnt_m[i_write_reg] == 0) err_m = 1'b1;
      if (!(issue && retire && i_issue_reg == i_write_reg)) begin
        if (issue) cnt_m[i_issue_reg]++;
        if (retire && cnt_m[i_write_reg] > 0) cnt_m[i_write_reg]--;
      end
    end
    @(negedge i_clk);
  endtask

  initial begin
    logic [4:0] r;
    model_clear();
    i_rst = 1'b1;
    drive(5'd3, 5'd4, 1'b1, 5'd3, 32'h1111_2222, 1'b1, 5'd3);
    @(negedge i_clk);
    check_all("in_reset");
    tick();
    i_rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // All registers read zero after reset
    for (int i = 0; i < 32; i += 2) begin
      drive(5'(i), 5'(i + 1), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      check_all("reset_reads");
    end

    // r0 ignores writes
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    check_all("r0_write");
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("r0_after");

    // Bypass then storage read
    drive(5'd5, 5'd1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    check_all("bypass_r5");
    tick();
    drive(5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("stored_r5");

    // Issue r7 then retire it
    drive(5'd1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    check_all("issue_r7");
    tick();
    drive(5'd1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("busy_r7");
    drive(5'd1, 5'd7, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
    check_all("retire_r7");
    tick();

    // Saturate r9
    for (int i = 0; i < 4; i++) begin
      drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      check_all("issue_r9");
      tick();
    end
    drive(5'd9, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    check_all("retire_r9_full");
    tick();
    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
    check_all("r9_not_full");

    // Randomized traffic; retires only target registers with a pending producer
    for (int n = 0; n < 400; n++) begin
      logic we;
      r  = 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 2) != 0) && (r == 0 || cnt_m[r] > 0);
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), we, r, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) i_rd_reg1 = r;
      if ($urandom_range(0, 3) == 0) i_rd_reg2 = r;
      if ($urandom_range(0, 5) == 0) i_issue_reg = r;
      check_all("random");
      tick();
    end

    // Asynchronous reset mid-stream, overlapping a commit to r10
    drive(5'd5, 5'd10, 1'b1, 5'd10, 32'hAAAA_5555, 1'b1, 5'd9);
    #2;
    i_rst = 1'b1;
    model_clear();
    check_all("async_rst");
    tick();
    check_all("rst_held");
    i_rst = 1'b0;
    drive(5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
    check_all("post_rst");

    // Issue and retire r4 together with count 1
    drive(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    drive(5'd4, 5'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
    check_all("r4_both");
    tick();
    drive(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4);
    check_all("r4_still_busy");

    // Underflow on r3 sets the sticky error
    drive(5'd3, 5'd4, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    check_all("r3_underflow");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      check_all("err_sticky");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
